ctrl_lectura_registros: RTL and testbench
=========================================

CTRL_LECTURA_REGISTROS -- requirements
Module: ctrl_lectura_registros

Interface
REQ-001 SHALL have parameter T_ESPERA, 255, max clk cycles spent waiting for bus_listo per register (8-bit range).
REQ-002 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port tick_lectura  in  1  single-cycle request to start a read sweep of the local registers.
REQ-005 SHALL have port funcion_conf  in  3  config mode: 000 normal, 001 hora, 010 fecha, 100 timer, others invalid.
REQ-006 SHALL have port bus_listo  in  1  single-cycle completion pulse from the RTC bus driver; read data valid in that cycle.
REQ-007 SHALL have port inicio_bus  out  1  single-cycle pulse commanding one RTC read transaction.
REQ-008 SHALL have port dir_rtc  out  8  RTC register address for the current transaction.
REQ-009 SHALL have port addr_mem_local  out  4  local register index 0..9 fed to the hold decoder.
REQ-010 SHALL have port reg_rd  out  1  active-low capture strobe to the hold decoder.
REQ-011 SHALL have port ocupado  out  1  high while a sweep is in progress.
REQ-012 SHALL have port barrido_listo  out  1  single-cycle pulse at sweep end.
REQ-013 SHALL have port error_bus  out  1  sticky flag set on timeout; cleared at next sweep start.

Function
REQ-014 FSM states SHALL be REPOSO, EMITE, ESPERA, CAPTURA, SIGUIENTE, FIN.
REQ-015 REPOSO: on tick_lectura=1 with funcion_conf in {000,001,010,100}, latch funcion_conf, set index=first non-skipped address, clear error_bus, go EMITE; with an invalid mode, stay in REPOSO.
REQ-016 Skip sets per latched mode: 000 none; 001 skips 0-2; 010 skips 3-6; 100 skips 7-9.
REQ-017 EMITE: one cycle with inicio_bus=1, dir_rtc=MAP[index], load wait counter=0, go ESPERA.
REQ-018 MAP SHALL be 0:0x21, 1:0x22, 2:0x23, 3:0x24, 4:0x25, 5:0x26, 6:0x27, 7:0x41, 8:0x42, 9:0x43.
REQ-019 ESPERA: on bus_listo=1 go CAPTURA; else increment counter; when counter reaches T_ESPERA, set error_bus and go FIN (abort sweep).
REQ-020 bus_listo in the same cycle the counter reaches T_ESPERA SHALL win: no error, go CAPTURA.
REQ-021 CAPTURA: exactly one cycle with reg_rd=0 and addr_mem_local=index, go SIGUIENTE.
REQ-022 Outside CAPTURA, reg_rd SHALL be 1; addr_mem_local SHALL hold the last index (0xF in REPOSO).
REQ-023 SIGUIENTE: advance index to the next non-skipped address <=9 and go EMITE; if none remains, go FIN.
REQ-024 FIN: barrido_listo=1 for one cycle, go REPOSO.
REQ-025 ocupado SHALL be 1 in every state except REPOSO.
REQ-026 tick_lectura while ocupado=1 SHALL be ignored (not queued).
REQ-027 funcion_conf changes mid-sweep SHALL NOT affect the sweep; the latched copy governs.
REQ-028 bus_listo outside ESPERA SHALL be ignored.
REQ-029 Full sweep latency (mode 000, bus_listo after k cycles) SHALL be 10*(k+3)+1 cycles from tick to barrido_listo.

Reset
REQ-030 reset=0 SHALL asynchronously force REPOSO, index=0, counter=0, inicio_bus=0, dir_rtc=0x00, addr_mem_local=0xF, reg_rd=1, ocupado=0, barrido_listo=0, error_bus=0.
REQ-031 Reset mid-sweep SHALL abort without any barrido_listo pulse; a new tick is required after release.

Structure
REQ-032 FSM state encoding, MAP address table, and mode codes SHALL live in a shared package/include common to the RTC control blocks.
REQ-033 The wait counter SHALL be a sub-module contador_espera (load, enable, terminal-count output).

Verification
REQ-034 Mode 000, tick, bus_listo 2 cycles after each inicio_bus -> 10 reg_rd pulses at addr 0..9, dir_rtc 0x21..0x27, 0x41..0x43, barrido_listo at cycle 51.
REQ-035 Mode 001, tick -> captures only at addr 3..9, no inicio_bus for 0x21..0x23; mode 100 -> captures only at 0..6.
REQ-036 bus_listo withheld at addr 4 -> error_bus=1 after 255 wait cycles, barrido_listo pulses, no reg_rd for addr 4..9; next tick clears error_bus.
REQ-037 Second tick and funcion_conf change to 010 mid-sweep -> sweep continues unchanged, one barrido_listo only.
REQ-038 reset=0 during ESPERA at addr 6 -> outputs immediately at reset values; no barrido_listo; mode 011 tick afterwards -> stays REPOSO.

Source files
------------

// File: rtl/ctrl_lectura_registros_pkg.sv
// Shared definitions for the RTC control blocks: FSM states, mode codes,
// the local-index to RTC-address map and the skip rules per mode.
package ctrl_lectura_registros_pkg;

  typedef enum logic [2:0] {
    REPOSO    = 3'd0,
    EMITE     = 3'd1,
    ESPERA    = 3'd2,
    CAPTURA   = 3'd3,
    SIGUIENTE = 3'd4,
    FIN       = 3'd5
  } estado_t;

  localparam logic [2:0] MODO_NORMAL = 3'b000;
  localparam logic [2:0] MODO_HORA   = 3'b001;
  localparam logic [2:0] MODO_FECHA  = 3'b010;
  localparam logic [2:0] MODO_TIMER  = 3'b100;

  localparam int         NUM_REGS   = 10;
  localparam int         CNT_W      = 8;
  localparam logic [3:0] IDX_REPOSO = 4'hF;

  // RTC register address for each local register index
  function automatic logic [7:0] dir_mapa(input logic [3:0] idx);
    logic [7:0] d;
    case (idx)
      4'd0:    d = 8'h21;
      4'd1:    d = 8'h22;
      4'd2:    d = 8'h23;
      4'd3:    d = 8'h24;
      4'd4:    d = 8'h25;
      4'd5:    d = 8'h26;
      4'd6:    d = 8'h27;
      4'd7:    d = 8'h41;
      4'd8:    d = 8'h42;
      4'd9:    d = 8'h43;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  function automatic logic modo_valido(input logic [2:0] m);
    return (m == MODO_NORMAL) || (m == MODO_HORA) ||
           (m == MODO_FECHA)  || (m == MODO_TIMER);
  endfunction

  // Registers that belong to the block being edited are not refreshed
  function automatic logic omite(input logic [2:0] m, input logic [3:0] idx);
    logic o;
    case (m)
      MODO_HORA:  o = (idx <= 4'd2);
      MODO_FECHA: o = (idx >= 4'd3) && (idx <= 4'd6);
      MODO_TIMER: o = (idx >= 4'd7);
      default:    o = 1'b0;
    endcase
    return o;
  endfunction

  // First non-skipped index >= desde; returns {found, index}
  function automatic logic [4:0] busca_indice(input logic [2:0] m,
                                              input logic [4:0] desde);
    logic [4:0] r;
    r = 5'b0;
    for (int j = NUM_REGS - 1; j >= 0; j--) begin
      if ((5'(j) >= desde) && !omite(m, 4'(j))) r = {1'b1, 4'(j)};
    end
    return r;
  endfunction

endpackage

// File: rtl/ctrl_lectura_registros_contador_espera.sv
// Wait counter for one RTC transaction: cleared on load, counts while
// enabled, flags the last allowed wait cycle.
module contador_espera
  import ctrl_lectura_registros_pkg::*;
#(
  parameter int T_ESPERA = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic carga,
  input  logic habilita,
  output logic cuenta_fin
);

  logic [CNT_W-1:0] cuenta;

  // Count wait cycles; load has priority over enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cuenta <= '0;
    else if (carga)    cuenta <= '0;
    else if (habilita) cuenta <= cuenta + CNT_W'(1);
  end

  // High on the T_ESPERA-th wait cycle: failing to see bus_listo now is a timeout
  assign cuenta_fin = (cuenta == CNT_W'(T_ESPERA - 1));

endmodule

// File: rtl/ctrl_lectura_registros.sv
// Sweeps the local RTC shadow registers: issues one bus read per register,
// waits for completion (with timeout), strobes the capture into the hold
// decoder, and skips the registers of the block currently being configured.
module ctrl_lectura_registros
  import ctrl_lectura_registros_pkg::*;
#(
  parameter int T_ESPERA = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_lectura,
  input  logic [2:0] funcion_conf,
  input  logic       bus_listo,
  output logic       inicio_bus,
  output logic [7:0] dir_rtc,
  output logic [3:0] addr_mem_local,
  output logic       reg_rd,
  output logic       ocupado,
  output logic       barrido_listo,
  output logic       error_bus
);

  estado_t    estado, estado_sig;
  logic [3:0] indice;
  logic [2:0] modo_lat;
  logic       cuenta_fin;
  logic       arranque;
  logic       vencido;
  logic [4:0] primero;
  logic [4:0] siguiente;

  assign arranque  = (estado == REPOSO) && tick_lectura && modo_valido(funcion_conf);
  assign vencido   = (estado == ESPERA) && !bus_listo && cuenta_fin;
  assign primero   = busca_indice(funcion_conf, 5'd0);
  assign siguiente = busca_indice(modo_lat, {1'b0, indice} + 5'd1);

  contador_espera #(
    .T_ESPERA (T_ESPERA)
  ) u_contador (
    .clk        (clk),
    .reset      (reset),
    .carga      (estado == EMITE),
    .habilita   ((estado == ESPERA) && !bus_listo),
    .cuenta_fin (cuenta_fin)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  // Next-state logic; bus_listo wins over a simultaneous timeout
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:    if (arranque) estado_sig = EMITE;
      EMITE:     estado_sig = ESPERA;
      ESPERA:    if (bus_listo)       estado_sig = CAPTURA;
                 else if (cuenta_fin) estado_sig = FIN;
      CAPTURA:   estado_sig = SIGUIENTE;
      SIGUIENTE: estado_sig = siguiente[4] ? EMITE : FIN;
      FIN:       estado_sig = REPOSO;
      default:   estado_sig = REPOSO;
    endcase
  end

  // Sweep context: latched mode, current index and sticky bus error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      modo_lat  <= MODO_NORMAL;
      indice    <= 4'd0;
      error_bus <= 1'b0;
    end else begin
      if (arranque) begin
        modo_lat  <= funcion_conf;
        indice    <= primero[3:0];
        error_bus <= 1'b0;
      end
      if (vencido) error_bus <= 1'b1;
      if ((estado == SIGUIENTE) && siguiente[4]) indice <= siguiente[3:0];
    end
  end

  // Moore outputs decoded from the state
  always_comb begin
    inicio_bus     = 1'b0;
    dir_rtc        = 8'h00;
    addr_mem_local = IDX_REPOSO;
    reg_rd         = 1'b1;
    ocupado        = 1'b1;
    barrido_listo  = 1'b0;
    if (estado != REPOSO) begin
      dir_rtc        = dir_mapa(indice);
      addr_mem_local = indice;
    end
    case (estado)
      REPOSO:  ocupado       = 1'b0;
      EMITE:   inicio_bus    = 1'b1;
      CAPTURA: reg_rd        = 1'b0;
      FIN:     barrido_listo = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_lectura_registros.sv
// Directed sequence of read sweeps with randomized bus latencies and
// spurious bus_listo pulses, checked against a behavioural sweep model.
module tb_ctrl_lectura_registros;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_lectura;
  logic [2:0] funcion_conf;
  logic       bus_listo;
  logic       inicio_bus;
  logic [7:0] dir_rtc;
  logic [3:0] addr_mem_local;
  logic       reg_rd;
  logic       ocupado;
  logic       barrido_listo;
  logic       error_bus;

  int total = 0;
  int bad   = 0;
  int dly [10];
  int corte;
  int perturba;

  always #5 clk = ~clk;

  ctrl_lectura_registros #(.T_ESPERA(255)) dut (
    .clk            (clk),
    .reset          (reset),
    .tick_lectura   (tick_lectura),
    .funcion_conf   (funcion_conf),
    .bus_listo      (bus_listo),
    .inicio_bus     (inicio_bus),
    .dir_rtc        (dir_rtc),
    .addr_mem_local (addr_mem_local),
    .reg_rd         (reg_rd),
    .ocupado        (ocupado),
    .barrido_listo  (barrido_listo),
    .error_bus      (error_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit omitido(input logic [2:0] m, input int i);
    case (m)
      3'b001:  return i < 3;
      3'b010:  return (i >= 3) && (i <= 6);
      3'b100:  return i >= 7;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int dir_de(input int i);
    return (i < 7) ? (32'h21 + i) : (32'h41 + i - 7);
  endfunction

  function automatic int idx_de(input logic [7:0] d);
    for (int i = 0; i < 10; i++) if (dir_de(i) == int'(d)) return i;
    return -1;
  endfunction

  task automatic paso();
    @(posedge clk);
    #1;
  endtask

  task automatic barrido(input logic [2:0] m, input string nom);
    int exp_idx [$];
    int exp_caps [$];
    int obs_dirs [$];
    int obs_caps [$];
    int exp_lat;
    int lat;
    int npulsos;
    int fire;
    int cur;
    bit cortado;
    exp_lat = 1;
    cortado = 1'b0;
    lat     = -1;
    npulsos = 0;
    fire    = -1;
    for (int i = 0; i < 10; i++) begin
      if (cortado || omitido(m, i)) continue;
      exp_idx.push_back(i);
      if (i == corte) begin
        cortado = 1'b1;
        exp_lat += 1 + 255;
      end else begin
        exp_caps.push_back(i);
        exp_lat += dly[i] + 3;
      end
    end

    tick_lectura = 1'b1;
    funcion_conf = m;
    paso();
    chk({nom, "_ocupado_ini"}, ocupado, 1);
    chk({nom, "_err_clr"}, error_bus, 0);
    for (int c = 1; c < 4000; c++) begin
      bus_listo    = 1'b0;
      tick_lectura = (perturba >= 0) && (c == perturba);
      funcion_conf = ((perturba >= 0) && (c >= perturba)) ? 3'b010 : m;
      if (inicio_bus === 1'b1) begin
        obs_dirs.push_back(int'(dir_rtc));
        cur  = idx_de(dir_rtc);
        fire = ((cur < 0) || (cur == corte)) ? -1 : c + dly[cur];
        if ($urandom_range(0, 1) == 1) bus_listo = 1'b1;
      end
      if (c == fire) bus_listo = 1'b1;
      if (reg_rd === 1'b0) begin
        obs_caps.push_back(int'(addr_mem_local));
        if ($urandom_range(0, 1) == 1) bus_listo = 1'b1;
      end
      if (barrido_listo === 1'b1) begin
        npulsos++;
        if (lat < 0) lat = c;
      end
      if ((lat >= 0) && (c >= lat + 4)) break;
      paso();
    end
    bus_listo    = 1'b0;
    tick_lectura = 1'b0;
    funcion_conf = m;

    chk({nom, "_latencia"}, lat, exp_lat);
    chk({nom, "_pulsos"}, npulsos, 1);
    chk({nom, "_n_emite"}, obs_dirs.size(), exp_idx.size());
    for (int i = 0; i < exp_idx.size() && i < obs_dirs.size(); i++)
      chk($sformatf("%s_dir%0d", nom, i), obs_dirs[i], dir_de(exp_idx[i]));
    chk({nom, "_n_captura"}, obs_caps.size(), exp_caps.size());
    for (int i = 0; i < exp_caps.size() && i < obs_caps.size(); i++)
      chk($sformatf("%s_cap%0d", nom, i), obs_caps[i], exp_caps[i]);
    chk({nom, "_error"}, error_bus, cortado);
    chk({nom, "_ocupado_fin"}, ocupado, 0);
    chk({nom, "_addr_reposo"}, addr_mem_local, 4'hF);
  endtask

  task automatic fija_dly(input int lo, input int hi);
    for (int i = 0; i < 10; i++) dly[i] = $urandom_range(hi, lo);
  endtask

  initial begin
    bit encontrado;
    int pulsos_rst;
    reset        = 1'b0;
    tick_lectura = 1'b0;
    funcion_conf = 3'b000;
    bus_listo    = 1'b0;
    corte        = -1;
    perturba     = -1;
    #1;
    chk("rst_inicio", inicio_bus, 0);
    chk("rst_dir", dir_rtc, 8'h00);
    chk("rst_addr", addr_mem_local, 4'hF);
    chk("rst_reg_rd", reg_rd, 1);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_listo", barrido_listo, 0);
    chk("rst_error", error_bus, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    paso();

    // full sweep, fixed latency of 2 cycles
    for (int i = 0; i < 10; i++) dly[i] = 2;
    barrido(3'b000, "normal_k2");

    // skipping modes with random latencies
    fija_dly(1, 6);
    barrido(3'b001, "hora");
    fija_dly(1, 6);
    barrido(3'b100, "timer");
    fija_dly(1, 6);
    barrido(3'b010, "fecha");

    // timeout at register 4
    fija_dly(1, 4);
    corte = 4;
    barrido(3'b000, "timeout");
    repeat (3) paso();
    chk("timeout_sticky", error_bus, 1);
    corte = -1;
    fija_dly(1, 3);
    barrido(3'b000, "tras_timeout");

    // completion on the very last allowed wait cycle
    fija_dly(1, 3);
    dly[5] = 255;
    barrido(3'b000, "limite");

    // ignored tick and mode change mid-sweep
    fija_dly(1, 5);
    perturba = 20;
    barrido(3'b000, "perturba");
    perturba = -1;

    // reset while waiting at register 6
    for (int i = 0; i < 10; i++) dly[i] = 2;
    tick_lectura = 1'b1;
    funcion_conf = 3'b000;
    paso();
    tick_lectura = 1'b0;
    encontrado = 1'b0;
    for (int c = 0; c < 200 && !encontrado; c++) begin
      bus_listo = 1'b0;
      if ((inicio_bus === 1'b1) && (dir_rtc == 8'h27)) encontrado = 1'b1;
      else if (inicio_bus === 1'b1) begin
        paso();
        paso();
        bus_listo = 1'b1;
        paso();
        bus_listo = 1'b0;
        continue;
      end
      if (!encontrado) paso();
    end
    chk("rst_busca_6", encontrado, 1);
    paso();
    chk("rst_espera_ocupado", ocupado, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rsta_inicio", inicio_bus, 0);
    chk("rsta_dir", dir_rtc, 8'h00);
    chk("rsta_addr", addr_mem_local, 4'hF);
    chk("rsta_reg_rd", reg_rd, 1);
    chk("rsta_ocupado", ocupado, 0);
    chk("rsta_listo", barrido_listo, 0);
    chk("rsta_error", error_bus, 0);
    pulsos_rst = 0;
    repeat (3) begin
      paso();
      if (barrido_listo !== 1'b0) pulsos_rst++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) begin
      paso();
      if ((barrido_listo !== 1'b0) || (ocupado !== 1'b0)) pulsos_rst++;
    end
    chk("rst_sin_barrido", pulsos_rst, 0);

    // invalid modes never start a sweep
    for (int m = 3; m < 8; m++) begin
      if (m == 4) continue;
      tick_lectura = 1'b1;
      funcion_conf = 3'(m);
      paso();
      tick_lectura = 1'b0;
      chk($sformatf("modo_inval_%0d", m), ocupado, 0);
      paso();
      chk($sformatf("modo_inval_%0d_b", m), inicio_bus, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
